// File: rtl/regfile_dump_reader.sv
// ============================================================================
// regfile_dump_reader
// ----------------------------------------------------------------------------
// Debug-side reader for the register file. A start pulse makes the block walk
// every register index 0..NUM_REGS-1 through a dedicated read port. Each
// register is streamed out as an {index, data} beat on a valid/ready
// interface. It gives the design a synthesizable way to dump the register file
// at the end of a run.
//
// The surrounding top level muxes rf_read_addr onto one register-file read
// port while busy is high. The core is expected to stall on busy.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   start         single-cycle dump request, honoured only while idle
//   abort         terminates a dump in progress (ignored while idle)
//   busy          high while this block owns the register-file read port
//   done          one-cycle pulse after the last beat has been accepted
//   rf_read_addr  register index presented to the register-file read port
//   rf_read_data  combinational read data for rf_read_addr
//   out_valid     output beat valid
//   out_ready     downstream accepts the current beat
//   out_index     register index carried by the current beat
//   out_data      register contents carried by the current beat
//   out_last      marks the beat for index NUM_REGS-1
// ============================================================================
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    state_t            next_state;

    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_d;
    logic              valid_d;
    logic [ADDR_W-1:0] index_d;
    logic [DATA_W-1:0] data_d;
    logic              last_d;
    logic              busy_d;
    logic              done_d;

    logic              handshake;
    logic              at_last;
    logic              abort_hit;

    assign handshake = out_valid & out_ready;
    assign at_last   = (idx == LAST_IDX);

    // An abort only means something once a dump has been started.
    assign abort_hit = abort & (state != ST_IDLE);

    // The walk index drives the read port directly. While idle it rests at 0.
    assign rf_read_addr = idx;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Abort overrides every other transition. A start
    // pulse that arrives together with an abort is also dropped.
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        if (abort_hit) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        next_state = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    next_state = ST_SEND;
                end
                ST_SEND: begin
                    if (handshake) begin
                        next_state = at_last ? ST_DONE : ST_FETCH;
                    end
                end
                ST_DONE: begin
                    next_state = ST_IDLE;
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath next values. The beat registers load only in
    // FETCH, so read data is captured exactly once per index. They then
    // hold until the handshake. busy and done are registered copies of
    // the state being entered. This keeps them glitch-free for the core
    // stall logic.
    // ------------------------------------------------------------------
    always_comb begin
        idx_d   = idx;
        valid_d = out_valid;
        index_d = out_index;
        data_d  = out_data;
        last_d  = out_last;
        busy_d  = (next_state != ST_IDLE);
        done_d  = (next_state == ST_DONE);

        if (abort_hit) begin
            idx_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    data_d  = rf_read_data;
                    index_d = idx;
                    last_d  = at_last;
                    valid_d = 1'b1;
                end
                ST_SEND: begin
                    if (handshake) begin
                        valid_d = 1'b0;
                        // The index stops at the last register rather than
                        // wrapping. DONE then parks it back at zero.
                        if (!at_last) begin
                            idx_d = idx + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    idx_d = '0;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            idx       <= idx_d;
            out_valid <= valid_d;
            out_index <= index_d;
            out_data  <= data_d;
            out_last  <= last_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug-side reader for the 32x32 register file.
- On a start pulse, walks every register index through a dedicated read port and streams {index, data} beats out over a valid/ready interface.
- Replaces the simulation-only end-of-run register print with a synthesizable dump path.
- Top level muxes this block's read address onto one register-file read port while busy is high; the core stalls on busy.

Parameters:
NUM_REGS, 32, number of registers walked (indices 0..NUM_REGS-1)
ADDR_W, 5, register index width; must satisfy 2^ADDR_W >= NUM_REGS
DATA_W, 32, register data width

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a dump; ignored unless idle
abort  input  1  terminate an in-progress dump
busy  output  1  high while the block owns the register-file read port
done  output  1  one-cycle pulse after the last beat is accepted
rf_read_addr  output  ADDR_W  register index driven to the register-file read port
rf_read_data  input  DATA_W  combinational read data returned for rf_read_addr
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts the beat
out_index  output  ADDR_W  register index of the current beat
out_data  output  DATA_W  register contents of the current beat
out_last  output  1  high on the beat for index NUM_REGS-1

Behaviour:
- Reset (asynchronous, immediate): state IDLE, idx=0; busy, done, out_valid, out_last, out_index and out_data all 0.
- State machine has four states: IDLE, FETCH, SEND, DONE.
- IDLE:
  - busy=0, rf_read_addr=idx (=0).
  - start=1 -> FETCH.
- FETCH (one cycle):
  - busy=1, rf_read_addr=idx.
  - At the clock edge: out_data<=rf_read_data, out_index<=idx, out_last<=(idx==NUM_REGS-1), out_valid<=1. Next state is SEND.
- SEND:
  - out_valid=1.
  - out_index, out_data and out_last are held stable until the out_valid&out_ready handshake.
  - On handshake with idx==NUM_REGS-1: out_valid<=0 -> DONE.
  - On handshake otherwise: out_valid<=0, idx<=idx+1 -> FETCH.
  - With no handshake: stay in SEND.
- DONE: busy=1, done=1 for exactly this cycle. idx<=0 -> IDLE.
- busy is registered: it rises the cycle after start is accepted and falls the cycle after DONE.
- Latency:
  - start sampled at edge 0 gives first out_valid after edge 1.
  - Each beat costs 2 cycles with out_ready held high, so a full dump is 2*NUM_REGS+1 cycles from start to done, plus 1 cycle for busy to fall.
- Read data is sampled only in FETCH.
  - A register-file write to the same index on the FETCH cycle edge is not captured: the old value is streamed.
  - Writes to indices already sent are not re-sent.
- start while busy=1 is ignored, and the dump in progress is unaffected.
- abort:
  - Takes effect in any non-IDLE state and has priority over handshake and start.
  - Next edge: state IDLE, idx=0, out_valid=0, out_last=0, no done pulse.
  - out_valid may therefore drop without a handshake, but only on abort.
- abort in IDLE has no effect.
- start and abort both high in IDLE: abort wins and the block stays IDLE.
- Register index 0 is dumped like any other index; no hardwired-zero special case is applied.
- idx never exceeds NUM_REGS-1; no wrap-around occurs during a dump.

Test Plan:
- Preload register i with 32'hA5A50000+i. Pulse start with out_ready=1.
  - Expect 32 beats in order, index 0..31, data A5A50000..A5A5001F.
  - out_last only on index 31.
  - done pulses at cycle 65 after start; busy falls the next cycle.
- Backpressure: toggle out_ready pseudo-randomly.
  - out_index, out_data and out_last stay stable while out_valid&!out_ready.
  - No beat is lost or duplicated; the 32-beat sequence is unchanged.
- Write register 5 with 32'hDEADBEEF on the FETCH cycle of index 5: beat 5 carries the old value 32'hA5A50005.
  - Writing register 3 after beat 3 is accepted: no extra beat is produced.
- Pulse start again during a dump at index 10: stream continues 11..31 with a single done.
- Assert abort while waiting in SEND at index 7:
  - Next cycle out_valid=0, busy=0, no done.
  - A new start restarts from index 0.
- Assert reset asynchronously mid-dump, between clock edges: all outputs are 0 immediately. After release, the block idles until start.
